// File: rtl/calc_pkg.sv
// Shared encodings for the calculator core: ALU opcodes and the button repeat FSM states.
package calc_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HELD   = 2'b01,
        REPEAT = 2'b10
    } rpt_state_e;

endpackage

// File: rtl/calc_unit_if.sv
// Button/switch inputs and operand/ALU outputs of the calculator core.
interface calc_unit_if #(
    parameter int unsigned WIDTH = 4
);
    import calc_pkg::*;

    logic             tick;
    logic [1:0]       btn;
    logic [1:0]       dir;
    logic [2:0]       op;
    logic             acc;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             ovf;

    modport master (
        output tick, btn, dir, op, acc,
        input  a_out, b_out, result, carry, zero, ovf
    );

    modport slave (
        input  tick, btn, dir, op, acc,
        output a_out, b_out, result, carry, zero, ovf
    );

endinterface

// File: rtl/btn_repeat.sv
// Rising-edge detect plus hold/auto-repeat FSM for one debounced button level.
module btn_repeat
    import calc_pkg::*;
#(
    parameter int unsigned HOLD_TICKS   = 64,
    parameter int unsigned REPEAT_TICKS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic level,
    output logic step
);

    localparam int unsigned MAX_TICKS = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int unsigned CNT_W     = $clog2(MAX_TICKS) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    rpt_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             rise;

    assign rise = level & ~level_q;

    // Step is decoded from the current state so the operand moves on the same edge.
    always_comb begin
        step = 1'b0;
        if (!rst && level) begin
            case (state)
                IDLE:    step = rise;
                HELD:    step = tick && (cnt == HOLD_LAST);
                REPEAT:  step = tick && (cnt == REPEAT_LAST);
                default: step = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // Loaded during reset too, so a level held through reset is not seen as a rise.
        level_q <= level;
        if (rst || !level) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= HELD;
                        cnt   <= '0;
                    end
                end
                HELD: begin
                    if (tick) begin
                        if (cnt == HOLD_LAST) begin
                            state <= REPEAT;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (tick) begin
                        if (cnt == REPEAT_LAST) cnt <= '0;
                        else                    cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/calc_unit.sv
// Operand entry registers driven by repeating buttons, plus a registered eight-op ALU
// whose result can be accumulated back into operand A.
module calc_unit
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned HOLD_TICKS   = 64,
    parameter int unsigned REPEAT_TICKS = 16
) (
    input  logic        clk,
    input  logic        rst,
    calc_unit_if.slave  bus
);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             ovf;
    } alu_out_t;

    function automatic alu_out_t alu(input op_e op, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
        alu_out_t       o;
        logic [WIDTH:0] ext;
        o   = '0;
        ext = '0;
        case (op)
            OP_ADD: begin
                ext     = {1'b0, a} + {1'b0, b};
                o.res   = ext[WIDTH-1:0];
                o.carry = ext[WIDTH];
                o.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // Carry is the inverted borrow: set when A >= B unsigned.
                ext     = {1'b0, a} - {1'b0, b};
                o.res   = ext[WIDTH-1:0];
                o.carry = ~ext[WIDTH];
                o.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: o.res = a & b;
            OP_OR:  o.res = a | b;
            OP_XOR: o.res = a ^ b;
            OP_SLT: o.res = WIDTH'($signed(a) < $signed(b));
            OP_SHL: begin
                o.res   = {a[WIDTH-2:0], 1'b0};
                o.carry = a[WIDTH-1];
            end
            OP_SHR: begin
                o.res   = {1'b0, a[WIDTH-1:1]};
                o.carry = a[0];
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    logic [1:0]       step;
    logic             acc_q;
    logic             acc_rise;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             zero_q;
    logic             ovf_q;
    alu_out_t         alu_o;

    btn_repeat #(
        .HOLD_TICKS  (HOLD_TICKS),
        .REPEAT_TICKS(REPEAT_TICKS)
    ) u_rpt_a (
        .clk  (clk),
        .rst  (rst),
        .tick (bus.tick),
        .level(bus.btn[0]),
        .step (step[0])
    );

    btn_repeat #(
        .HOLD_TICKS  (HOLD_TICKS),
        .REPEAT_TICKS(REPEAT_TICKS)
    ) u_rpt_b (
        .clk  (clk),
        .rst  (rst),
        .tick (bus.tick),
        .level(bus.btn[1]),
        .step (step[1])
    );

    assign acc_rise = bus.acc & ~acc_q;
    assign alu_o    = alu(op_e'(bus.op), a_q, b_q);

    always_ff @(posedge clk) begin
        acc_q <= bus.acc;
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            // Accumulate wins over an A step in the same cycle; that step is lost.
            if (acc_rise) begin
                a_q <= result_q;
            end else if (step[0]) begin
                a_q <= bus.dir[0] ? a_q - WIDTH'(1) : a_q + WIDTH'(1);
            end
            if (step[1]) begin
                b_q <= bus.dir[1] ? b_q - WIDTH'(1) : b_q + WIDTH'(1);
            end
            result_q <= alu_o.res;
            carry_q  <= alu_o.carry;
            zero_q   <= (alu_o.res == '0);
            ovf_q    <= alu_o.ovf;
        end
    end

    assign bus.a_out  = a_q;
    assign bus.b_out  = b_q;
    assign bus.result = result_q;
    assign bus.carry  = carry_q;
    assign bus.zero   = zero_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_calc_unit.sv
// Directed plus random checks of calc_unit against an arithmetic model of operands and ALU.
module tb_calc_unit;

    localparam int W  = 4;
    localparam int HT = 4;
    localparam int RT = 2;
    localparam int M  = 1 << W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    calc_unit_if #(.WIDTH(W)) bus ();

    calc_unit #(
        .WIDTH       (W),
        .HOLD_TICKS  (HT),
        .REPEAT_TICKS(RT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int m_a    = 0;
    int m_b    = 0;
    int m_op   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= M / 2) ? x - M : x;
    endfunction

    function automatic void ref_alu(input int op, input int a, input int b,
                                    output int r, output int c, output int v);
        int s;
        r = 0; c = 0; v = 0;
        case (op)
            0: begin
                s = a + b; r = s % M; c = (s >= M) ? 1 : 0;
                s = sgn(a) + sgn(b); v = (s > M / 2 - 1 || s < -M / 2) ? 1 : 0;
            end
            1: begin
                r = (a - b + M) % M; c = (a >= b) ? 1 : 0;
                s = sgn(a) - sgn(b); v = (s > M / 2 - 1 || s < -M / 2) ? 1 : 0;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (sgn(a) < sgn(b)) ? 1 : 0;
            6: begin r = (a * 2) % M; c = (a >= M / 2) ? 1 : 0; end
            default: begin r = a / 2; c = a % 2; end
        endcase
    endfunction

    task automatic check_alu(input string tag);
        int r, c, v;
        ref_alu(m_op, m_a, m_b, r, c, v);
        check({tag, "_result"}, 32'(bus.result), r);
        check({tag, "_carry"}, 32'(bus.carry), c);
        check({tag, "_ovf"}, 32'(bus.ovf), v);
        check({tag, "_zero"}, 32'(bus.zero), (r == 0) ? 1 : 0);
    endtask

    // One-clk press; the result register has caught up by the time this returns.
    task automatic press(input int idx, input bit d);
        bus.dir[idx] = d;
        bus.btn[idx] = 1'b1;
        @(negedge clk);
        bus.btn[idx] = 1'b0;
        @(negedge clk);
        if (idx == 0) m_a = (m_a + (d ? M - 1 : 1)) % M;
        else          m_b = (m_b + (d ? M - 1 : 1)) % M;
    endtask

    task automatic set_val(input int idx, input int target);
        int n;
        n = (target - ((idx == 0) ? m_a : m_b) + M) % M;
        repeat (n) press(idx, 1'b0);
    endtask

    task automatic set_op(input int op);
        m_op   = op;
        bus.op = 3'(op);
        @(negedge clk);
    endtask

    initial begin
        int b0, exp_b, r, c, v, act;
        rst      = 1'b1;
        bus.tick = 1'b0;
        bus.btn  = 2'b01;
        bus.dir  = 2'b00;
        bus.op   = 3'd0;
        bus.acc  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_a", 32'(bus.a_out), 0);
        check("rst_b", 32'(bus.b_out), 0);
        check("rst_result", 32'(bus.result), 0);
        check("rst_carry", 32'(bus.carry), 0);
        check("rst_zero", 32'(bus.zero), 1);
        check("rst_ovf", 32'(bus.ovf), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("held_through_rst_a", 32'(bus.a_out), 0);
        bus.btn = 2'b00;
        @(negedge clk);

        for (int i = 1; i <= M; i++) begin
            press(0, 1'b0);
            check("count_up_a", 32'(bus.a_out), m_a);
        end
        press(0, 1'b1);
        check("count_down_wrap_a", 32'(bus.a_out), m_a);

        set_val(0, 9); set_val(1, 8); set_op(0);
        check_alu("add_9_8");
        set_val(0, 3); set_val(1, 5); set_op(1);
        check_alu("sub_3_5");
        set_op(5);
        check_alu("slt_3_5");
        set_val(0, 9); set_op(6);
        check_alu("shl_9");
        set_op(7);
        check_alu("shr_9");

        // Auto-repeat: steps at edges k, k+HT, then every RT edges while held.
        set_val(1, 0);
        b0          = m_b;
        bus.tick    = 1'b1;
        bus.dir[1]  = 1'b0;
        bus.btn[1]  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp_b = (i < HT) ? 1 : 2 + (i - HT) / RT;
            check("repeat_b", 32'(bus.b_out), (b0 + exp_b) % M);
        end
        bus.btn[1] = 1'b0;
        repeat (6) @(negedge clk);
        m_b = (b0 + 4) % M;
        check("repeat_release_b", 32'(bus.b_out), m_b);
        bus.tick = 1'b0;

        set_val(0, 5); set_val(1, 3); set_op(0);
        check_alu("acc_pre_add");
        ref_alu(m_op, m_a, m_b, r, c, v);
        bus.acc    = 1'b1;
        bus.dir[0] = 1'b0;
        bus.btn[0] = 1'b1;
        @(negedge clk);
        m_a = r;
        check("acc_priority_a", 32'(bus.a_out), m_a);
        bus.acc    = 1'b0;
        bus.btn[0] = 1'b0;
        @(negedge clk);
        check_alu("acc_post_add");

        for (int i = 0; i < 40; i++) begin
            set_op(int'($urandom_range(0, 7)));
            act = int'($urandom_range(0, 3));
            case (act)
                0: press(0, 1'($urandom_range(0, 1)));
                1: press(1, 1'($urandom_range(0, 1)));
                2: begin
                    ref_alu(m_op, m_a, m_b, r, c, v);
                    bus.acc = 1'b1;
                    @(negedge clk);
                    bus.acc = 1'b0;
                    @(negedge clk);
                    m_a = r;
                end
                default: ;
            endcase
            check("rand_a", 32'(bus.a_out), m_a);
            check("rand_b", 32'(bus.b_out), m_b);
            check_alu("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_unit.md
# calc_unit

Parametrised operand-entry and ALU core for the board calculator, the successor to the fixed 4-bit button/ALU path. It takes debounced push-button levels and switch settings and holds two WIDTH-bit operand registers. Each button steps its operand up or down, with auto-repeat while held. A registered ALU computes one of eight operations with carry/zero/overflow flags, and an accumulate button writes the result back into operand A. It sits between the debouncers and the seven-segment display driver.

## Interface
- WIDTH, 4: operand/result width, ≥2
- HOLD_TICKS, 64: ticks a button must be held before auto-repeat starts, ≥1
- REPEAT_TICKS, 16: ticks between auto-repeat steps, ≥1
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- tick  in  1  timebase enable (e.g. a divided-clock strobe), one clk wide; all hold/repeat counts are in ticks
- btn  in  2  debounced button levels; btn[0] steps A, btn[1] steps B
- dir  in  2  step direction per operand; 0 = +1, 1 = −1
- op  in  3  ALU operation select
- acc  in  1  debounced accumulate button level
- a_out  out  WIDTH  operand A register
- b_out  out  WIDTH  operand B register
- result  out  WIDTH  registered ALU result
- carry  out  1  registered carry/borrow/shift-out flag
- zero  out  1  registered, result == 0
- ovf  out  1  registered signed overflow

## Operation
- Reset: a_out = b_out = result = 0, carry = ovf = 0, zero = 1, both repeat FSMs IDLE, counters 0. Edge-detect registers load the current btn/acc, so a button held through reset release does not produce a step.
- Edge detect: rise = level & ~level_q, sampled every clk.
- Repeat FSM per button. All states go to IDLE when the button level is 0.
  - IDLE: on rise, emit step, clear cnt, go to HELD.
  - HELD: on tick, cnt++; on tick with cnt == HOLD_TICKS−1, emit step, clear cnt, go to REPEAT.
  - REPEAT: on tick with cnt == REPEAT_TICKS−1, emit step, clear cnt; otherwise on tick, cnt++.
- Step: the operand becomes operand ± 1 modulo 2^WIDTH (15+1 → 0, 0−1 → 15 for WIDTH = 4). dir is sampled in the step cycle.
- Accumulate: on an acc rise, a_out ← result. This has priority over an A step in the same cycle; that A step is dropped and the FSM still advances. B steps are unaffected.
- ALU ops (A = a_out, B = b_out):
  - 000 ADD: carry = carry-out; ovf = signed overflow
  - 001 SUB A−B: carry = 1 when there is no borrow (A ≥ B unsigned); ovf = signed overflow
  - 010 AND, 011 OR, 100 XOR: carry = ovf = 0
  - 101 SLT: result = 1 if A < B signed, else 0; carry = ovf = 0
  - 110 SHL A by 1: carry = A[WIDTH−1]
  - 111 SHR A by 1, logical: carry = A[0]
  - ovf = 0 for every op except ADD and SUB.
- Counter width: clog2 of max(HOLD_TICKS, REPEAT_TICKS) + 1.

## Timing
- If the button rises before edge k, a_out/b_out change at edge k.
- result and flags reflect the operands and op from the previous cycle, one clk after any change; op changes take effect one cycle later.
- An acc rise at edge k writes the result held before edge k. The new result appears at k+1.
- Auto-repeat with tick every clk: steps occur at edges k, k+HOLD_TICKS, then every REPEAT_TICKS edges.
- Release in any state stops stepping immediately: no step occurs on the cycle the level is 0.
- Reset mid-hold aborts the repeat, and no step occurs on the reset cycle.

## Structure
- Package calc_pkg holds:
  - op encodings (OP_ADD … OP_SHR)
  - the repeat-FSM state enum (IDLE, HELD, REPEAT)
- Sub-module btn_repeat contains the edge detect, FSM and counter, with parameters HOLD_TICKS and REPEAT_TICKS and a step output. It is instantiated twice.
- The ALU is a combinational function inside calc_unit, feeding the result/flag registers.

## Test plan
- Reset, with btn[0] held through rst release: all outputs 0, zero = 1, no A step after release.
- WIDTH = 4, dir = 0, 16 separate btn[0] presses: A counts 1..15 then reaches 0. dir = 1, one press from 0: A = 15.
- A = 9, B = 8, ADD: result = 1, carry = 1, ovf = 1, zero = 0. SUB with A = 3, B = 5: result = 14, carry = 0, ovf = 0. SLT: result = 1.
- A = 0b1001, SHL: result = 0b0010, carry = 1. SHR: result = 0b0100, carry = 1.
- HOLD_TICKS = 4, REPEAT_TICKS = 2, tick every clk, btn[1] held for 10 cycles from edge k: B steps at k, k+4, k+6, k+8, so B = 4. No further steps after release.
- A = 5, B = 3, ADD, acc rise and btn[0] rise in the same cycle: A = 8 (step dropped). Result = 11 one cycle later.
